// File: rtl/ccsds_pkg.sv
// Shared types and constants for the CCSDS TM frame sequencer.
// PN taps realise s[n+8] = s[n+7]^s[n+5]^s[n+3]^s[n] with pn[7] holding the oldest bit.
package ccsds_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ASM,
        SEQ_DATA
    } seq_state_e;

    localparam int unsigned CCSDS_ASM_W   = 32;
    localparam int unsigned CCSDS_PN_W    = 8;
    localparam logic [CCSDS_ASM_W-1:0] CCSDS_ASM     = 32'h1ACF_FC1D;
    localparam logic [CCSDS_PN_W-1:0]  CCSDS_PN_SEED = 8'hFF;
    localparam logic [CCSDS_PN_W-1:0]  CCSDS_PN_TAPS = 8'h95;

    function automatic logic [CCSDS_PN_W-1:0] pn_next(input logic [CCSDS_PN_W-1:0] pn);
        return {pn[CCSDS_PN_W-2:0], ^(pn & CCSDS_PN_TAPS)};
    endfunction

endpackage

// File: rtl/ccsds_frame_sequencer_pn_gen.sv
// 8-bit Fibonacci LFSR producing the CCSDS randomizer sequence, MSB out.
module ccsds_pn_gen
    import ccsds_pkg::*;
#(
    parameter logic [CCSDS_PN_W-1:0] SEED = CCSDS_PN_SEED
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic init_i,
    input  logic step_i,
    output logic pn_o
);

    logic [CCSDS_PN_W-1:0] pn_q;
    logic [CCSDS_PN_W-1:0] pn_d;

    always_comb begin
        pn_d = pn_q;
        if (init_i) begin
            pn_d = SEED;
        end else if (step_i) begin
            pn_d = pn_next(pn_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pn_q <= SEED;
        end else begin
            pn_q <= pn_d;
        end
    end

    assign pn_o = pn_q[CCSDS_PN_W-1];

endmodule

// File: rtl/ccsds_frame_sequencer.sv
// Byte-to-bit CCSDS TM framer: emits ASM then FRAME_BYTES of PN-randomized data per frame.
// All outputs are decoded from registered state only.
module ccsds_frame_sequencer
    import ccsds_pkg::*;
#(
    parameter int unsigned                FRAME_BYTES = 223,
    parameter logic [CCSDS_ASM_W-1:0]     ASM_WORD    = CCSDS_ASM,
    parameter logic [CCSDS_PN_W-1:0]      PN_SEED     = CCSDS_PN_SEED
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic       bit_o,
    output logic       bit_valid_o,
    input  logic       bit_ready_i,
    output logic       frame_start_o,
    output logic       frame_done_o,
    output logic       underrun_o,
    output logic       len_err_o,
    output logic       busy_o
);

    localparam int unsigned     BC_W      = $clog2(FRAME_BYTES + 1);
    localparam int unsigned     AC_W      = $clog2(CCSDS_ASM_W);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(FRAME_BYTES - 1);
    localparam logic [AC_W-1:0] LAST_ASM  = AC_W'(CCSDS_ASM_W - 1);

    seq_state_e             state_q, state_d;
    logic                   ready_en_q, ready_en_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [7:0]             shift_q, shift_d;
    logic                   shift_valid_q, shift_valid_d;
    logic [CCSDS_ASM_W-1:0] asm_sr_q, asm_sr_d;
    logic [AC_W-1:0]        asm_cnt_q, asm_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [BC_W-1:0]        in_cnt_q, in_cnt_d;
    logic                   underrun_q, underrun_d;
    logic                   len_err_q, len_err_d;
    logic                   frame_done_q, frame_done_d;

    logic bit_valid_c, bit_acc_c, in_acc_c, pn_out_c;
    logic pn_init_c, pn_step_c, go_asm_c, load_shift_c;

    ccsds_pn_gen #(.SEED(PN_SEED)) u_pn (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .init_i (pn_init_c),
        .step_i (pn_step_c),
        .pn_o   (pn_out_c)
    );

    assign bit_valid_c = (state_q == SEQ_ASM) || ((state_q == SEQ_DATA) && shift_valid_q);
    assign bit_acc_c   = bit_valid_c && bit_ready_i;
    assign in_acc_c    = s_valid_i && s_ready_o;

    always_comb begin
        state_d       = state_q;
        ready_en_d    = 1'b1;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        shift_d       = shift_q;
        shift_valid_d = shift_valid_q;
        asm_sr_d      = asm_sr_q;
        asm_cnt_d     = asm_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        in_cnt_d      = in_cnt_q;
        underrun_d    = underrun_q;
        len_err_d     = len_err_q;
        frame_done_d  = 1'b0;
        pn_init_c     = 1'b0;
        pn_step_c     = 1'b0;
        go_asm_c      = 1'b0;
        load_shift_c  = 1'b0;

        // Input side tracks its own byte position so s_last_i is checked, never trusted.
        if (in_acc_c) begin
            hold_d = s_data_i;
            if (s_last_i != (in_cnt_q == LAST_BYTE)) begin
                len_err_d = 1'b1;
            end
            in_cnt_d = (in_cnt_q == LAST_BYTE) ? '0 : in_cnt_q + BC_W'(1);
        end

        unique case (state_q)
            SEQ_IDLE: begin
                go_asm_c = hold_valid_q && enable_i;
            end
            SEQ_ASM: begin
                if (bit_acc_c) begin
                    asm_sr_d  = asm_sr_q << 1;
                    asm_cnt_d = asm_cnt_q + AC_W'(1);
                    if (asm_cnt_q == LAST_ASM) begin
                        state_d      = SEQ_DATA;
                        pn_init_c    = 1'b1;
                        bit_cnt_d    = '0;
                        byte_cnt_d   = '0;
                        load_shift_c = hold_valid_q;
                        underrun_d   = underrun_q || !hold_valid_q;
                    end
                end
            end
            SEQ_DATA: begin
                if (bit_acc_c) begin
                    pn_step_c = 1'b1;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        shift_valid_d = 1'b0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_d = 1'b1;
                            byte_cnt_d   = '0;
                            go_asm_c     = hold_valid_q && enable_i;
                            state_d      = SEQ_IDLE;
                        end else begin
                            byte_cnt_d   = byte_cnt_q + BC_W'(1);
                            load_shift_c = hold_valid_q;
                            underrun_d   = underrun_q || !hold_valid_q;
                        end
                    end
                end else if (!shift_valid_q && hold_valid_q) begin
                    load_shift_c = 1'b1;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        if (go_asm_c) begin
            state_d   = SEQ_ASM;
            asm_sr_d  = ASM_WORD;
            asm_cnt_d = '0;
        end
        if (load_shift_c) begin
            shift_d       = hold_q;
            shift_valid_d = 1'b1;
        end
        hold_valid_d = (hold_valid_q && !load_shift_c) || in_acc_c;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SEQ_IDLE;
            ready_en_q    <= 1'b0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            shift_q       <= '0;
            shift_valid_q <= 1'b0;
            asm_sr_q      <= '0;
            asm_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            in_cnt_q      <= '0;
            underrun_q    <= 1'b0;
            len_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_en_q    <= ready_en_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            shift_q       <= shift_d;
            shift_valid_q <= shift_valid_d;
            asm_sr_q      <= asm_sr_d;
            asm_cnt_q     <= asm_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            in_cnt_q      <= in_cnt_d;
            underrun_q    <= underrun_d;
            len_err_q     <= len_err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign s_ready_o     = ready_en_q && !hold_valid_q;
    assign bit_valid_o   = bit_valid_c;
    assign bit_o         = (state_q == SEQ_ASM)  ? asm_sr_q[CCSDS_ASM_W-1] :
                           (state_q == SEQ_DATA) ? (shift_valid_q && (shift_q[7] ^ pn_out_c)) :
                           1'b0;
    assign frame_start_o = (state_q == SEQ_ASM) && (asm_cnt_q == '0);
    assign frame_done_o  = frame_done_q;
    assign underrun_o    = underrun_q;
    assign len_err_o     = len_err_q;
    assign busy_o        = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_ccsds_frame_sequencer.sv
// Directed bench for ccsds_frame_sequencer with FRAME_BYTES=5 and hand-computed bit streams.
module tb_ccsds_frame_sequencer;

    localparam int unsigned FB      = 5;
    localparam int unsigned TIMEOUT = 2000;
    localparam logic [71:0]  EXP_F00 = {32'h1ACFFC1D, 40'hFF480EC09A};
    localparam logic [143:0] EXP_B2B = {32'h1ACFFC1D, 40'hFF480EC09A, 32'h1ACFFC1D, 40'h00B7F13F65};

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b1;
    logic [7:0] s_data_i = 8'h00;
    logic       s_valid_i = 1'b0;
    logic       s_last_i = 1'b0;
    logic       bit_ready_i;
    logic       s_ready_o, bit_o, bit_valid_o, frame_start_o, frame_done_o;
    logic       underrun_o, len_err_o, busy_o;

    logic bp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic bits_q[$];
    int   starts = 0;
    int   dones = 0;
    int   gaps = 0;
    int   done_at = 0;
    int   base, base_starts, base_gaps;

    ccsds_frame_sequencer #(.FRAME_BYTES(FB)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .bit_o         (bit_o),
        .bit_valid_o   (bit_valid_o),
        .bit_ready_i   (bit_ready_i),
        .frame_start_o (frame_start_o),
        .frame_done_o  (frame_done_o),
        .underrun_o    (underrun_o),
        .len_err_o     (len_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream ready: always 1 unless random backpressure is enabled.
    initial begin
        bit_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            bit_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Bit-side monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bit_valid_o && bit_ready_i) begin
                bits_q.push_back(bit_o);
                if (frame_start_o) starts++;
            end
            if (busy_o && !bit_valid_o) gaps++;
            if (frame_done_o) begin
                dones++;
                done_at = bits_q.size();
            end
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        while (!s_ready_o && t < TIMEOUT) begin
            tick(1);
            t++;
        end
        if (t >= TIMEOUT) check("s_ready_o timeout", 160'(s_ready_o), 160'(1));
        tick(1);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int last_idx);
        for (int i = 0; i < FB; i++) send_byte(d, (i == last_idx));
    endtask

    task automatic wait_dones(input int target);
        int t = 0;
        while (dones < target && t < TIMEOUT) begin
            tick(1);
            t++;
        end
        if (t >= TIMEOUT) check("frame_done timeout", 160'(dones), 160'(target));
    endtask

    function automatic logic [159:0] pack_bits(input int b, input int n);
        logic [159:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[158:0], (b + i < bits_q.size()) ? bits_q[b + i] : 1'b0};
        end
        return v;
    endfunction

    initial begin
        // 1: reset values, ready delay after release, reset mid-frame
        tick(3);
        check("in-reset outputs", 160'({bit_o, bit_valid_o, s_ready_o, frame_start_o,
              frame_done_o, underrun_o, len_err_o, busy_o}), 160'(0));
        rst_ni = 1'b1;
        check("s_ready first cycle", 160'(s_ready_o), 160'(0));
        tick(1);
        check("s_ready after release", 160'(s_ready_o), 160'(1));
        check("busy after release", 160'(busy_o), 160'(0));
        send_byte(8'h00, 1'b0);
        tick(6);
        check("busy/valid mid-frame", 160'({busy_o, bit_valid_o}), 160'(2'b11));
        rst_ni = 1'b0;
        #1;
        check("async reset outputs", 160'({bit_o, bit_valid_o, s_ready_o, frame_start_o,
              frame_done_o, underrun_o, len_err_o, busy_o}), 160'(0));
        tick(1);
        rst_ni = 1'b1;
        check("s_ready after re-release", 160'(s_ready_o), 160'(0));
        tick(1);
        check("s_ready next cycle", 160'(s_ready_o), 160'(1));

        // 2: single frame of 00 bytes
        base = bits_q.size();
        base_gaps = gaps;
        send_frame(8'h00, FB - 1);
        wait_dones(1);
        check("frame1 bit count", 160'(bits_q.size() - base), 160'(72));
        check("frame1 done after bit 72", 160'(done_at - base), 160'(72));
        check("frame1 bits", pack_bits(base, 72), 160'(EXP_F00));
        check("frame1 no bubbles", 160'(gaps - base_gaps), 160'(0));
        tick(2);
        check("frame1 idle", 160'(busy_o), 160'(0));

        // 3: back-to-back frames, PN restarts on the second
        base = bits_q.size();
        base_starts = starts;
        base_gaps = gaps;
        send_frame(8'h00, FB - 1);
        send_frame(8'hFF, FB - 1);
        wait_dones(3);
        check("b2b bit count", 160'(bits_q.size() - base), 160'(144));
        check("b2b bits", pack_bits(base, 144), 160'(EXP_B2B));
        check("b2b frame_start count", 160'(starts - base_starts), 160'(2));
        check("b2b zero gap", 160'(gaps - base_gaps), 160'(0));

        // 4: random downstream backpressure
        tick(2);
        base = bits_q.size();
        bp_en = 1'b1;
        send_frame(8'h00, FB - 1);
        wait_dones(4);
        bp_en = 1'b0;
        tick(2);
        check("bp bits", pack_bits(base, 72), 160'(EXP_F00));
        check("bp bit count", 160'(bits_q.size() - base), 160'(72));
        check("bp no underrun", 160'(underrun_o), 160'(0));

        // 5: input stall before byte 2 causes a bubble, PN continuity kept
        base = bits_q.size();
        base_gaps = gaps;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        tick(20);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_dones(5);
        tick(2);
        check("stall underrun", 160'(underrun_o), 160'(1));
        check("stall bubble seen", 160'(gaps - base_gaps > 0), 160'(1));
        check("stall bits", pack_bits(base, 72), 160'(EXP_F00));
        check("no len_err yet", 160'(len_err_o), 160'(0));

        // 6: misplaced s_last_i, then enable_i dropped before frame end
        base = bits_q.size();
        send_frame(8'h00, 2);
        enable_i = 1'b0;
        wait_dones(6);
        check("len_err set", 160'(len_err_o), 160'(1));
        check("len_err frame bits", pack_bits(base, 72), 160'(EXP_F00));
        check("len_err frame count", 160'(bits_q.size() - base), 160'(72));
        send_byte(8'h00, 1'b0);
        tick(5);
        check("disabled stays idle", 160'({busy_o, bit_valid_o}), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
